// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and small helpers used by the register file.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    // Width of a flat bus that carries n fields of w bits each.
    function automatic int flat_w(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode / write-back facing bus of the multi-port register file.
interface regfile_mp_if import mips_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) ();

    logic                                WB;
    logic [ADDR_W-1:0]                   writeReg;
    logic [DATA_W-1:0]                   writeData;
    logic [flat_w(NUM_RD, ADDR_W)-1:0]   readReg;
    logic [flat_w(NUM_RD, DATA_W)-1:0]   RegData;
    logic                                issueValid;
    logic [ADDR_W-1:0]                   issueReg;
    logic [NUM_RD-1:0]                   busyRd;

    // Pipeline side: drives writes, reads and issues.
    modport master (
        output WB, writeReg, writeData, readReg, issueValid, issueReg,
        input  RegData, busyRd
    );

    // Register file side.
    modport slave (
        input  WB, writeReg, writeData, readReg, issueValid, issueReg,
        output RegData, busyRd
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set on issue, clear on write-back, set wins.
module regfile_scoreboard import mips_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_en,
    input  logic [ADDR_W-1:0]         clr_idx,
    input  logic                      set_en,
    input  logic [ADDR_W-1:0]         set_idx,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_idx,
    output logic [NUM_RD-1:0]         busy_rd
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Next busy vector: clear first so a same-edge issue re-marks the register.
    always_comb begin
        busy_nxt = busy;
        if (clr_en && clr_idx != ADDR_W'(REG_ZERO)) busy_nxt[clr_idx] = 1'b0;
        if (set_en && set_idx != ADDR_W'(REG_ZERO)) busy_nxt[set_idx] = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    // Lookups use the next state so busy_rd lines up with same-edge read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            busy_rd <= '0;
        end else begin
            busy <= busy_nxt;
            for (int p = 0; p < NUM_RD; p++)
                busy_rd[p] <= busy_nxt[rd_idx[p*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, zero register and scoreboard.
module regfile_mp import mips_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]          regs [DEPTH];
    logic                       wr_en;
    logic [NUM_RD*DATA_W-1:0]   rd_flat;

    assign wr_en = bus.WB && (bus.writeReg != ADDR_W'(REG_ZERO));

    // Storage array; entry 0 is never written and never read from.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[bus.writeReg] <= bus.writeData;
        end
    end

    // One registered read port per generate iteration.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_q;

        assign ra = bus.readReg[p*ADDR_W +: ADDR_W];

        // Zero register, then same-cycle write bypass, then array.
        always_ff @(posedge clk) begin
            if (rst)                                 rd_q <= '0;
            else if (ra == ADDR_W'(REG_ZERO))        rd_q <= '0;
            else if (bus.WB && bus.writeReg == ra)   rd_q <= bus.writeData;
            else                                     rd_q <= regs[ra];
        end

        assign rd_flat[p*DATA_W +: DATA_W] = rd_q;
    end

    assign bus.RegData = rd_flat;

    regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .clr_en  (bus.WB),
        .clr_idx (bus.writeReg),
        .set_en  (bus.issueValid),
        .set_idx (bus.issueReg),
        .rd_idx  (bus.readReg),
        .busy_rd (bus.busyRd)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default 2-port config via vector table, plus a 4-port/64-bit sweep.
module tb_regfile_mp;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
    regfile_mp_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4)) ifb ();

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave)
    );
    regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        wb;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic        iv;
        logic [4:0]  ireg;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic wb, logic [4:0] wreg, logic [31:0] wdata,
                                logic [4:0] r0, logic [4:0] r1, logic iv, logic [4:0] ireg,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb);
        vec_t v;
        v.rst = r; v.wb = wb; v.wreg = wreg; v.wdata = wdata; v.r0 = r0; v.r1 = r1;
        v.iv = iv; v.ireg = ireg; v.e0 = e0; v.e1 = e1; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_b();
        ifb.WB = 1'b0; ifb.writeReg = '0; ifb.writeData = '0;
        ifb.readReg = '0; ifb.issueValid = 1'b0; ifb.issueReg = '0;
    endtask

    localparam logic [63:0] V1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] V2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] V3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] V4 = 64'h4444_4444_4444_4444;

    initial begin
        logic [63:0] vals [4];
        n_chk  = 0;
        n_fail = 0;
        idle_b();
        vals[0] = V1; vals[1] = V2; vals[2] = V3; vals[3] = V4;

        //          rst wb wreg wdata          r0  r1  iv ireg e0             e1             eb
        vt.push_back(mk(1, 0, 0,  32'h0,          0,  0,  0, 0,  32'h0,         32'h0,         2'b00));
        vt.push_back(mk(0, 1, 9,  32'h5,          0,  0,  0, 0,  32'h0,         32'h0,         2'b00));
        vt.push_back(mk(0, 0, 0,  32'h0,          9,  9,  0, 0,  32'h5,         32'h5,         2'b00));
        vt.push_back(mk(0, 1, 20, 32'd50,         9,  20, 0, 0,  32'h5,         32'd50,        2'b00));
        vt.push_back(mk(0, 1, 0,  32'hDEADBEEF,   0,  20, 1, 0,  32'h0,         32'd50,        2'b00));
        vt.push_back(mk(0, 0, 0,  32'h0,          10, 9,  1, 10, 32'h0,         32'h5,         2'b01));
        vt.push_back(mk(0, 0, 0,  32'h0,          10, 10, 0, 0,  32'h0,         32'h0,         2'b11));
        vt.push_back(mk(0, 0, 0,  32'h0,          10, 10, 0, 0,  32'h0,         32'h0,         2'b11));
        vt.push_back(mk(0, 1, 10, 32'd77,         10, 9,  0, 0,  32'd77,        32'h5,         2'b00));
        vt.push_back(mk(0, 1, 11, 32'd33,         11, 10, 1, 11, 32'd33,        32'd77,        2'b01));
        vt.push_back(mk(0, 0, 0,  32'h0,          11, 11, 0, 0,  32'd33,        32'd33,        2'b11));
        vt.push_back(mk(0, 0, 0,  32'h0,          12, 11, 1, 12, 32'h0,         32'd33,        2'b11));
        vt.push_back(mk(1, 1, 5,  32'd99,         11, 12, 1, 13, 32'h0,         32'h0,         2'b00));
        vt.push_back(mk(0, 0, 0,  32'h0,          9,  11, 0, 0,  32'h0,         32'h0,         2'b00));
        vt.push_back(mk(0, 0, 0,  32'h0,          12, 5,  0, 0,  32'h0,         32'h0,         2'b00));
        vt.push_back(mk(0, 1, 31, 32'hFFFFFFFF,   31, 0,  0, 0,  32'hFFFFFFFF,  32'h0,         2'b00));
        vt.push_back(mk(0, 0, 0,  32'h0,          31, 31, 0, 0,  32'hFFFFFFFF,  32'hFFFFFFFF,  2'b00));

        // Table: one edge per vector, checked 1 time unit after the edge.
        for (int i = 0; i < vt.size(); i++) begin
            rst            = vt[i].rst;
            ifa.WB         = vt[i].wb;
            ifa.writeReg   = vt[i].wreg;
            ifa.writeData  = vt[i].wdata;
            ifa.readReg    = {vt[i].r1, vt[i].r0};
            ifa.issueValid = vt[i].iv;
            ifa.issueReg   = vt[i].ireg;
            @(posedge clk); #1;
            chk($sformatf("vec%0d RegData0", i), 64'(ifa.RegData[31:0]),  64'(vt[i].e0));
            chk($sformatf("vec%0d RegData1", i), 64'(ifa.RegData[63:32]), 64'(vt[i].e1));
            chk($sformatf("vec%0d busyRd", i),   64'(ifa.busyRd),         64'(vt[i].eb));
            if (i == 0) chk("b reset RegData", ifb.RegData[63:0], 64'h0);
        end

        // Preload several registers and busy bits, reset one cycle, sweep every index.
        ifa.readReg = '0; ifa.issueValid = 1'b0;
        for (int r = 1; r < 8; r++) begin
            ifa.WB = 1'b1; ifa.writeReg = 5'(r); ifa.writeData = 32'hA000_0000 + 32'(r);
            ifa.issueValid = 1'b1; ifa.issueReg = 5'(r + 20);
            @(posedge clk); #1;
        end
        rst = 1'b1; ifa.WB = 1'b1; ifa.writeReg = 5'd3; ifa.writeData = 32'hBAD;
        @(posedge clk); #1;
        rst = 1'b0; ifa.WB = 1'b0; ifa.issueValid = 1'b0;
        for (int r = 0; r < 32; r += 2) begin
            ifa.readReg = {5'(r + 1), 5'(r)};
            @(posedge clk); #1;
            chk($sformatf("post-rst r%0d/r%0d", r, r + 1),
                {ifa.RegData, 30'(ifa.busyRd)}, 94'h0);
        end

        // Wide config: write four registers, then read all four in one cycle.
        idle_b();
        for (int r = 0; r < 4; r++) begin
            ifb.WB = 1'b1; ifb.writeReg = 4'(r + 1); ifb.writeData = vals[r];
            @(posedge clk); #1;
        end
        idle_b();
        ifb.readReg = {4'd4, 4'd3, 4'd2, 4'd1};
        @(posedge clk); #1;
        for (int p = 0; p < 4; p++)
            chk($sformatf("b port%0d", p), ifb.RegData[p*64 +: 64], vals[p]);
        ifb.readReg = {4'd1, 4'd2, 4'd3, 4'd4};
        ifb.issueValid = 1'b1; ifb.issueReg = 4'd1;
        @(posedge clk); #1;
        for (int p = 0; p < 4; p++)
            chk($sformatf("b swap port%0d", p), ifb.RegData[p*64 +: 64], vals[3 - p]);
        chk("b busyRd", 64'(ifb.busyRd), 64'h8);
        idle_b();
        ifb.readReg = {4'd15, 4'd15, 4'd15, 4'd15};
        ifb.WB = 1'b1; ifb.writeReg = 4'd15; ifb.writeData = 64'hCAFE_F00D_0123_4567;
        @(posedge clk); #1;
        chk("b bypass all ports", ifb.RegData,
            {4{64'hCAFE_F00D_0123_4567}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the MIPS pipeline, the successor to the single-configuration register file. Provides NUM_RD registered read ports, one write-back port with same-cycle write-to-read bypass, hardwired-zero register 0, synchronous clear, and a per-register busy scoreboard that the decode stage uses for hazard detection. Sits between decode (read/issue side) and write-back (write side).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- WB  in  1  write-back enable
- writeReg  in  ADDR_W  write-back destination index
- writeData  in  DATA_W  write-back data
- readReg  in  NUM_RD*ADDR_W  read indices, port p at bits [p*ADDR_W +: ADDR_W]
- RegData  out  NUM_RD*DATA_W  read data, port p at bits [p*DATA_W +: DATA_W]
- issueValid  in  1  decode issues an instruction that will write issueReg
- issueReg  in  ADDR_W  destination of the issued instruction
- busyRd  out  NUM_RD  per read port: source register has a write outstanding

## Operation
- Storage: 2**ADDR_W x DATA_W registers; index 0 always reads 0, writes to 0 ignored.
- Write: on edge with WB=1 and writeReg!=0, registersArray[writeReg] <= writeData.
- Read (per port p, every edge): RegData[p] <= 0 if readReg[p]==0; else writeData if WB && writeReg==readReg[p]; else registersArray[readReg[p]].
- Scoreboard: busy vector of 2**ADDR_W bits, bit 0 permanently 0.
  - Edge with WB and writeReg!=0: clear busy[writeReg].
  - Edge with issueValid and issueReg!=0: set busy[issueReg].
  - Same register, same edge, both events: set wins (new producer).
- busyRd[p] <= next-state busy[readReg[p]] (after applying this edge's clear/set), so it agrees with RegData sampled the same edge.
- Reset: all registers, busy bits, RegData, busyRd cleared to 0; WB and issueValid ignored during a reset cycle.
- Multiple read ports addressing the same register return identical values.

## Timing
- Read latency 1 cycle: readReg presented before edge N, RegData/busyRd valid after edge N until edge N+1.
- Write visible to a same-cycle read via bypass; visible to array reads from edge N+1 onward.
- Issue at edge N: busyRd of a port reading that register is 1 after edge N.
- Write-back at edge N clears busy; busyRd reads 0 after edge N (unless re-issued at same edge).
- rst asserted at edge N: all outputs 0 after edge N; first write accepted at the first edge with rst=0.
- Reset mid-operation discards in-flight issues; no residual busy bits.
- No combinational path from inputs to outputs.

## Structure
- Shared package mips_pkg: DATA_W and ADDR_W defaults, REG_ZERO constant (0), helper for flat-port slicing widths.
- Sub-module regfile_scoreboard: busy vector with set/clear/priority and NUM_RD lookup; top holds storage, bypass, and output registers.
- Read ports generated with a generate loop over NUM_RD.

## Test plan
- Reset: preload via writes, assert rst one cycle -> every read returns 0, busyRd=0 on all ports.
- Write then read: WB=1, writeReg=9, writeData=5; next cycle readReg[0]=9 -> RegData[0]=5 one cycle later.
- Bypass: same cycle WB=1, writeReg=20, writeData=50, readReg[1]=20 -> RegData[1]=50 after that edge.
- Zero register: WB=1, writeReg=0, writeData=0xDEADBEEF; readReg[0]=0, issueValid with issueReg=0 -> RegData[0]=0, busyRd[0]=0.
- Scoreboard: issue reg 10 at edge N -> busyRd=1 for port reading 10; WB to 10 at edge N+3 -> busyRd=0; simultaneous issue+WB to 11 -> busyRd stays 1.
- Config sweep: NUM_RD=4, DATA_W=64, ADDR_W=4; all ports read distinct written registers (0x1111.., 0x2222.., etc.) -> each port returns its own value in same cycle.
